// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: default widths and vectors plus the fetch-state and next-PC select enums
package pc_redirect_unit_pkg;
  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0004;
  typedef enum logic [1:0] {FETCH, WAIT_MEM, REDIRECT_PEND} fetch_state_e;
  typedef enum logic [1:0] {NPC_INC, NPC_HOLD, NPC_TGT, NPC_PEND} npc_sel_e;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC select (inc/hold/target/pending) with target alignment, or trap on misalign when PC_MISALIGN_TRAP_EN is defined
module pc_next_mux
  import pc_redirect_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  npc_sel_e          sel,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   target,
  input  logic [XLEN-1:0]   pend,
  output logic [XLEN-1:0]   next_pc,
  output logic              tgt_misalign
);
  logic [XLEN-1:0] src;
  logic            src_misalign;
  assign src = sel == NPC_TGT ? target : pend;
`ifdef PC_MISALIGN_TRAP_EN
  assign src_misalign = |src[1:0];
  assign tgt_misalign = |target[1:0];
`else
  assign src_misalign = 1'b0;
  assign tgt_misalign = 1'b0;
`endif
  assign next_pc = sel == NPC_INC  ? pc + XLEN'(4) :
                   sel == NPC_HOLD ? pc :
                   src_misalign    ? TRAP_VECTOR : src & ~XLEN'(3);
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: IF-stage PC register, fetch sequencing, redirect/flush control with pending redirect across imem busywait (optional PC_MISALIGN_TRAP_EN)
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(DEFAULT_TRAP_VECTOR)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            PC_SEL,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  input  logic            STALL,
  input  logic            IMEM_BUSYWAIT,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_PLUS4,
  output logic            IMEM_READ,
  output logic            IF_VALID,
  output logic            FLUSH_IF_ID,
  output logic            FLUSH_ID_EX,
  output logic            MISALIGN
);
  fetch_state_e    state, next_state;
  npc_sel_e        sel;
  logic [XLEN-1:0] pend_target, next_pc;
  logic            tgt_misalign;
  always_comb begin
    sel = IMEM_BUSYWAIT          ? NPC_HOLD :
          PC_SEL                 ? NPC_TGT :
          state == REDIRECT_PEND ? NPC_PEND :
          STALL                  ? NPC_HOLD : NPC_INC;
    next_state = PC_SEL && IMEM_BUSYWAIT ? REDIRECT_PEND :
                 !IMEM_BUSYWAIT          ? FETCH :
                 state == FETCH          ? WAIT_MEM : state;
  end
  pc_next_mux #(.XLEN(XLEN), .TRAP_VECTOR(TRAP_VECTOR)) u_mux (
    .sel(sel),
    .pc(PC),
    .target(BRANCH_TARGET),
    .pend(pend_target),
    .next_pc(next_pc),
    .tgt_misalign(tgt_misalign)
  );
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= FETCH;
      PC <= RESET_VECTOR;
      pend_target <= '0;
    end else begin
      state <= next_state;
      PC <= next_pc;
      if (PC_SEL && IMEM_BUSYWAIT) pend_target <= BRANCH_TARGET;
    end
  end
  assign PC_PLUS4 = PC + XLEN'(4);
  assign IMEM_READ = !RESET;
  assign FLUSH_IF_ID = !RESET && PC_SEL;
  assign FLUSH_ID_EX = !RESET && PC_SEL;
  assign MISALIGN = !RESET && PC_SEL && tgt_misalign;
  assign IF_VALID = !RESET && !PC_SEL && !IMEM_BUSYWAIT &&
                    (state == WAIT_MEM || (state == FETCH && !STALL));
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plus random stimulus checked against a behavioural fetch/redirect model
module tb_pc_redirect_unit;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  logic clk = 1'b0;
  logic RESET = 1'b1, PC_SEL = 1'b0, STALL = 1'b0, IMEM_BUSYWAIT = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic [31:0] PC, PC_PLUS4;
  logic IMEM_READ, IF_VALID, FLUSH_IF_ID, FLUSH_ID_EX, MISALIGN;
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_pend;
  bit m_known = 0, m_pending = 0, m_waiting = 0;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .CLK(clk), .RESET(RESET), .PC_SEL(PC_SEL), .BRANCH_TARGET(BRANCH_TARGET),
    .STALL(STALL), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .PC(PC), .PC_PLUS4(PC_PLUS4),
    .IMEM_READ(IMEM_READ), .IF_VALID(IF_VALID), .FLUSH_IF_ID(FLUSH_IF_ID),
    .FLUSH_ID_EX(FLUSH_ID_EX), .MISALIGN(MISALIGN)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] land(input logic [31:0] x);
    logic [31:0] a;
    a = x & 32'hFFFF_FFFC;
    return (FEAT && a != x) ? 32'h4 : a;
  endfunction

  task automatic step(input bit r, input bit s, input logic [31:0] t, input bit st, input bit b);
    bit exp_valid, exp_mis;
    @(negedge clk);
    RESET = r; PC_SEL = s; BRANCH_TARGET = t; STALL = st; IMEM_BUSYWAIT = b;
    #1;
    exp_valid = !r && !s && !b && !m_pending && (m_waiting || !st);
    exp_mis = FEAT && !r && s && (t & 32'h3) != 0;
    chk("imem_read", IMEM_READ, !r);
    chk("flush_if_id", FLUSH_IF_ID, !r && s);
    chk("flush_id_ex", FLUSH_ID_EX, !r && s);
    chk("if_valid", IF_VALID, exp_valid);
    chk("misalign", MISALIGN, exp_mis);
    if (m_known) begin
      chk("pc", PC, m_pc);
      chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
    end
    if (r) begin
      m_pc = 32'h0; m_known = 1; m_pending = 0; m_waiting = 0;
    end else if (s && b) begin
      m_pending = 1; m_pend = t;
    end else if (s) begin
      m_pc = land(t); m_pending = 0; m_waiting = 0;
    end else if (b) begin
      if (!m_pending) m_waiting = 1;
    end else if (m_pending) begin
      m_pc = land(m_pend); m_pending = 0; m_waiting = 0;
    end else begin
      if (!st) m_pc = m_pc + 32'd4;
      m_waiting = 0;
    end
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] v);
    @(posedge clk);
    #1;
    chk(tag, PC, v);
  endtask

  initial begin
    logic [31:0] t;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
    step(0, 1, 32'h100, 0, 0);
    expect_pc("redirect_pc", 32'h100);
    step(0, 0, 0, 0, 0);
    expect_pc("redirect_next", 32'h104);
    step(0, 1, 32'h200, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    expect_pc("pending_pc", 32'h200);
    step(0, 1, 32'h40, 1, 0);
    expect_pc("stall_redirect", 32'h40);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    expect_pc("stall_hold", 32'h40);
    step(0, 1, 32'h300, 0, 1);
    step(0, 1, 32'h400, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    expect_pc("latest_pending", 32'h400);
    step(0, 1, 32'h102, 0, 0);
    expect_pc("misalign_pc", FEAT ? 32'h4 : 32'h100);
    step(0, 1, 32'h500, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    expect_pc("reset_pc", 32'h0);
    step(0, 0, 0, 0, 0);
    expect_pc("reset_discard", 32'h4);
    step(0, 1, 32'hFFFF_FFF8, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    expect_pc("wrap_zero", 32'h0);
    for (int i = 0; i < 600; i++) begin
      t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, t,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
